// File: rtl/wrm_pkg.sv
// wrm_pkg: opcodes, instruction layout and shared types for the washing register machine.
package wrm_pkg;
    localparam int INSTR_WIDTH_DFLT = 32;

    localparam logic [7:0] OP_HALT    = 8'h00;
    localparam logic [7:0] OP_WAIT    = 8'h11;
    localparam logic [7:0] OP_FILL    = 8'h12;
    localparam logic [7:0] OP_RELEASE = 8'h13;
    localparam logic [7:0] OP_FORWARD = 8'h14;
    localparam logic [7:0] OP_REVERSE = 8'h15;
    localparam logic [7:0] OP_SET     = 8'h21;
    localparam logic [7:0] OP_DEC     = 8'h22;
    localparam logic [7:0] OP_J       = 8'h30;
    localparam logic [7:0] OP_JZ      = 8'h31;
    localparam logic [7:0] OP_JNZ     = 8'h32;

    typedef struct packed {
        logic [15:0] imm;
        logic [7:0]  reg_idx;
        logic [7:0]  op;
    } instr_t;

    typedef enum logic {ST_INIT, ST_READY} state_t;
endpackage

// File: rtl/wrm_prog_store_if.sv
// wrm_prog_store_if: fetch, slot-select and loader-write signals of the program store.
interface wrm_prog_store_if #(
    parameter int INSTR_WIDTH = wrm_pkg::INSTR_WIDTH_DFLT,
    parameter int ADDR_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2
);
    logic                   start;
    logic [SEL_WIDTH-1:0]   prog_sel;
    logic [SEL_WIDTH-1:0]   active_slot;
    logic                   fetch_en;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   running;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [SEL_WIDTH-1:0]   wr_slot;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INSTR_WIDTH-1:0] wr_data;
    logic                   wr_err;
    logic                   init_done;

    modport master (
        output start, prog_sel, fetch_en, pc, running, wr_valid, wr_slot, wr_addr, wr_data,
        input  active_slot, instr, instr_valid, wr_ready, wr_err, init_done
    );
    modport slave (
        input  start, prog_sel, fetch_en, pc, running, wr_valid, wr_slot, wr_addr, wr_data,
        output active_slot, instr, instr_valid, wr_ready, wr_err, init_done
    );
endinterface

// File: rtl/wrm_sram_1r1w.sv
// wrm_sram_1r1w: 1-read/1-write synchronous array, registered read-before-write output.
module wrm_sram_1r1w #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
        if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    end
endmodule

// File: rtl/wrm_prog_store.sv
// wrm_prog_store: multi-slot writable program store; clears itself to HALT after reset,
// then serves 1-cycle fetches from the active slot and protected loader writes.
module wrm_prog_store
    import wrm_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DFLT,
    parameter int ADDR_WIDTH  = 8,
    parameter int SLOT_DEPTH  = 64,
    parameter int NUM_SLOTS   = 4,
    parameter int SEL_WIDTH   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input logic clk,
    input logic rst_n,
    wrm_prog_store_if.slave bus
);
    localparam int DEPTH = NUM_SLOTS * SLOT_DEPTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state_q, state_d;
    logic [AW-1:0]          clr_q, clr_d;
    logic [SEL_WIDTH-1:0]   active_q;
    logic                   valid_q, zero_q, err_q;
    logic                   ready, fetch, pc_ok, xfer, wr_ok, mem_we;
    logic [AW-1:0]          mem_wa;
    logic [INSTR_WIDTH-1:0] mem_wd, rd_data;

    function automatic logic slot_ok(input logic [SEL_WIDTH-1:0] s);
        return {1'b0, s} < (SEL_WIDTH + 1)'(NUM_SLOTS);
    endfunction

    function automatic logic [AW-1:0] phys(input logic [SEL_WIDTH-1:0] s, input logic [ADDR_WIDTH-1:0] a);
        return AW'(s) * AW'(SLOT_DEPTH) + AW'(a);
    endfunction

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ready   = state_q == ST_READY;
        if (!ready) begin
            clr_d   = clr_q + 1'b1;
            state_d = (clr_q == AW'(DEPTH - 1)) ? ST_READY : ST_INIT;
        end
    end

    assign fetch  = ready && bus.fetch_en;
    assign pc_ok  = {1'b0, bus.pc} < (ADDR_WIDTH + 1)'(SLOT_DEPTH);
    assign xfer   = ready && bus.wr_valid;
    // protection compares against the slot held before any same-cycle start
    assign wr_ok  = slot_ok(bus.wr_slot) && ({1'b0, bus.wr_addr} < (ADDR_WIDTH + 1)'(SLOT_DEPTH))
                    && !(bus.running && bus.wr_slot == active_q);
    assign mem_we = !ready || (xfer && wr_ok);
    assign mem_wa = ready ? phys(bus.wr_slot, bus.wr_addr) : clr_q;
    assign mem_wd = ready ? bus.wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            clr_q    <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            valid_q <= fetch;
            err_q   <= xfer && !wr_ok;
            if (fetch) zero_q <= !pc_ok;
            if (ready && bus.start && slot_ok(bus.prog_sel)) active_q <= bus.prog_sel;
        end
    end

    wrm_sram_1r1w #(.WIDTH(INSTR_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk       (clk),
        .rd_en_i   (fetch && pc_ok),
        .rd_addr_i (phys(active_q, bus.pc)),
        .rd_data_o (rd_data),
        .we_i      (mem_we),
        .wr_addr_i (mem_wa),
        .wr_data_i (mem_wd)
    );

    // zero_q masks the array output after reset and for out-of-range fetches
    assign bus.instr       = zero_q ? '0 : rd_data;
    assign bus.instr_valid = valid_q;
    assign bus.active_slot = active_q;
    assign bus.wr_ready    = ready;
    assign bus.wr_err      = err_q;
    assign bus.init_done   = ready;
endmodule

// File: tb/tb_wrm_prog_store.sv
// tb_wrm_prog_store: directed vector table plus hand-written init/reset sequences.
module tb_wrm_prog_store;
    import wrm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wrm_prog_store_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(8), .SEL_WIDTH(2)) bus ();
    wrm_prog_store_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(8), .SEL_WIDTH(2)) bus3 ();

    wrm_prog_store #(.NUM_SLOTS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    wrm_prog_store #(.NUM_SLOTS(3), .SEL_WIDTH(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    typedef struct {
        logic        st;
        logic [1:0]  sel;
        logic        run;
        logic        wv;
        logic [1:0]  ws;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        fe;
        logic [7:0]  pc;
        logic        ev;
        logic [31:0] ei;
        logic        ee;
        logic [1:0]  ea;
    } vec_t;

    vec_t vecs[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        {bus.start, bus.prog_sel, bus.fetch_en, bus.pc, bus.running} = '0;
        {bus.wr_valid, bus.wr_slot, bus.wr_addr, bus.wr_data} = '0;
        {bus3.start, bus3.prog_sel, bus3.fetch_en, bus3.pc, bus3.running} = '0;
        {bus3.wr_valid, bus3.wr_slot, bus3.wr_addr, bus3.wr_data} = '0;
    endtask

    task automatic wait_init;
        for (int c = 1; c <= 256; c++) begin
            tick;
            if (c == 191) chk("dut3 init_done at 191", bus3.init_done, 0);
            if (c == 192) chk("dut3 init_done at 192", bus3.init_done, 1);
            if (c == 255) begin
                chk("init_done at 255", bus.init_done, 0);
                chk("wr_ready at 255", bus.wr_ready, 0);
            end
            if (c == 256) begin
                chk("init_done at 256", bus.init_done, 1);
                chk("wr_ready at 256", bus.wr_ready, 1);
            end
        end
    endtask

    task automatic start_slot(input logic [1:0] s);
        bus.start = 1'b1;
        bus.prog_sel = s;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [7:0] p, input logic [31:0] exp);
        bus.fetch_en = 1'b1;
        bus.pc = p;
        tick;
        bus.fetch_en = 1'b0;
        chk({name, " instr"}, bus.instr, exp);
        chk({name, " valid"}, bus.instr_valid, 1);
    endtask

    initial begin
        clear_inputs;
        tick;
        tick;
        chk("rst instr", bus.instr, 0);
        chk("rst instr_valid", bus.instr_valid, 0);
        chk("rst active_slot", bus.active_slot, 0);
        chk("rst wr_ready", bus.wr_ready, 0);
        chk("rst wr_err", bus.wr_err, 0);
        chk("rst init_done", bus.init_done, 0);
        rst_n = 1'b1;
        wait_init;

        for (int s = 0; s < 4; s++) begin
            start_slot(2'(s));
            chk($sformatf("sweep s%0d active", s), bus.active_slot, 32'(s));
            chk($sformatf("sweep s%0d idle valid", s), bus.instr_valid, 0);
            for (int p = 0; p < 64; p++) fetch_chk($sformatf("sweep s%0d pc%0d", s, p), 8'(p), 0);
        end

        // st sel run wv ws wa wd fe pc | valid instr err active
        vecs.push_back('{0, 0, 0, 1, 2, 5, {16'd20, 8'd0, OP_FORWARD}, 0, 0,   0, 32'h0,         0, 3});
        vecs.push_back('{1, 2, 0, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0,         0, 2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 5,   1, 32'h0014_0014, 0, 2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0014_0014, 0, 2});
        vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0014_0014, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 1, 7, {16'hDEAD, 8'h00, OP_WAIT}, 0, 0,   0, 32'h0014_0014, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0014_0014, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 3, 7, {16'd5, 8'h01, OP_SET},     0, 0,   0, 32'h0014_0014, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 32'h0,                      1, 7,   1, 32'h0,         0, 1});
        vecs.push_back('{1, 3, 0, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0,         0, 3});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 7,   1, 32'h0005_0121, 0, 3});
        vecs.push_back('{0, 0, 0, 1, 0, 64, 32'hFFFF_FFFF,             1, 200, 1, 32'h0,         1, 3});
        vecs.push_back('{0, 0, 0, 1, 0, 63, {16'h1111, 8'h22, OP_JZ},  0, 0,   0, 32'h0,         0, 3});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 32'h0,                      0, 0,   0, 32'h0,         0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 63,  1, 32'h1111_2231, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 63, {16'h2222, 8'h01, OP_J},   1, 63,  1, 32'h1111_2231, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 63,  1, 32'h2222_0130, 0, 0});
        vecs.push_back('{1, 2, 1, 1, 0, 1, 32'h5555_5555,              0, 0,   0, 32'h2222_0130, 1, 2});
        vecs.push_back('{0, 0, 1, 1, 2, 1, {16'd3, 8'h03, OP_WAIT},    0, 0,   0, 32'h2222_0130, 1, 2});
        vecs.push_back('{0, 0, 0, 1, 2, 1, {16'd3, 8'h03, OP_WAIT},    0, 0,   0, 32'h2222_0130, 0, 2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 1,   1, 32'h0003_0311, 0, 2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 5,   1, 32'h0014_0014, 0, 2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,                      1, 64,  1, 32'h0,         0, 2});

        foreach (vecs[i]) begin
            bus.start = vecs[i].st;
            bus.prog_sel = vecs[i].sel;
            bus.running = vecs[i].run;
            bus.wr_valid = vecs[i].wv;
            bus.wr_slot = vecs[i].ws;
            bus.wr_addr = vecs[i].wa;
            bus.wr_data = vecs[i].wd;
            bus.fetch_en = vecs[i].fe;
            bus.pc = vecs[i].pc;
            tick;
            chk($sformatf("vec%0d instr", i), bus.instr, vecs[i].ei);
            chk($sformatf("vec%0d valid", i), bus.instr_valid, vecs[i].ev);
            chk($sformatf("vec%0d wr_err", i), bus.wr_err, vecs[i].ee);
            chk($sformatf("vec%0d active", i), bus.active_slot, vecs[i].ea);
        end
        clear_inputs;

        // three-slot instance: slot 3 is out of range for start and writes
        bus3.start = 1'b1;
        bus3.prog_sel = 2'd3;
        tick;
        bus3.start = 1'b0;
        chk("dut3 start slot3 ignored", bus3.active_slot, 0);
        bus3.wr_valid = 1'b1;
        bus3.wr_slot = 2'd3;
        bus3.wr_data = 32'h1234_5678;
        tick;
        chk("dut3 slot3 write err", bus3.wr_err, 1);
        bus3.wr_slot = 2'd2;
        bus3.wr_data = {16'hABCD, 8'h00, OP_FILL};
        tick;
        chk("dut3 slot2 write ok", bus3.wr_err, 0);
        bus3.wr_valid = 1'b0;
        bus3.start = 1'b1;
        bus3.prog_sel = 2'd2;
        tick;
        bus3.start = 1'b0;
        chk("dut3 start slot2", bus3.active_slot, 2);
        bus3.fetch_en = 1'b1;
        tick;
        bus3.fetch_en = 1'b0;
        chk("dut3 fetch instr", bus3.instr, 32'hABCD_0012);
        chk("dut3 fetch valid", bus3.instr_valid, 1);

        // reset in the middle of a write burst
        bus.fetch_en = 1'b1;
        bus.pc = 8'd5;
        bus.wr_valid = 1'b1;
        bus.wr_slot = 2'd1;
        bus.wr_addr = 8'd0;
        bus.wr_data = 32'hCAFE_0000;
        tick;
        chk("burst fetch instr", bus.instr, 32'h0014_0014);
        bus.wr_addr = 8'd1;
        bus.wr_data = 32'hCAFE_0001;
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst instr", bus.instr, 0);
        chk("async rst valid", bus.instr_valid, 0);
        chk("async rst active", bus.active_slot, 0);
        chk("async rst init_done", bus.init_done, 0);
        chk("async rst wr_ready", bus.wr_ready, 0);
        clear_inputs;
        tick;
        rst_n = 1'b1;
        wait_init;
        start_slot(2'd1);
        fetch_chk("post-rst s1 pc0", 8'd0, 0);
        fetch_chk("post-rst s1 pc1", 8'd1, 0);
        start_slot(2'd2);
        fetch_chk("post-rst s2 pc5", 8'd5, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
